// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and default slice geometry.
package alu_pkg;

    localparam int ADD_SLICE_W = 8;
    localparam int ADD_SLICES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_adder8.sv
// Combinational N-bit ripple-carry slice; also exposes the carry into its MSB.
import alu_pkg::*;

module adder8 #(
    parameter int N = ADD_SLICE_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/wide_add_seq.sv
// Wide adder that reuses one N-bit slice over SLICES cycles, LSB slice first.
// Define WIDE_ADD_SUB_EN to add the op_sub port and subtraction support.
import alu_pkg::*;

module wide_add_seq #(
    parameter int N      = ADD_SLICE_W,
    parameter int SLICES = ADD_SLICES,
    parameter int W      = N * SLICES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef WIDE_ADD_SUB_EN
    input  logic         op_sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic [1:0]   dbg_state
);

    localparam int IW = $clog2(SLICES);

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          sub;

    logic [N-1:0]  slice_s;
    logic          slice_cout;
    logic          slice_c_msb;

`ifdef WIDE_ADD_SUB_EN
    assign sub = op_sub;
`else
    assign sub = 1'b0;
`endif

    adder8 #(.N(N)) u_slice (
        .a     (a_q[idx*N +: N]),
        .b     (b_q[idx*N +: N]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                RUN: begin
                    sum[idx*N +: N] <= slice_s;
                    carry_q         <= slice_cout;
                    if (idx == IW'(SLICES - 1)) begin
                        // Only the top slice's MSB carries define signed overflow.
                        state <= DONE;
                        cout  <= slice_cout;
                        ovf   <= slice_cout ^ slice_c_msb;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
